// File: rtl/accel_pkg.sv
// Shared accelerator types and constants for the PE accumulator drain path.
package accel_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int INT8_MIN  = -128;
  localparam int INT8_MAX  = 127;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_STREAM
  } drain_state_t;

endpackage

// File: rtl/sat_requant.sv
// Arithmetic right shift of a signed accumulator followed by int8 saturation.
import accel_pkg::*;

module sat_requant #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [7:0]       q_o
);

  localparam logic signed [ACC_W-1:0] LO = ACC_W'(INT8_MIN);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(INT8_MAX);

  logic signed [ACC_W-1:0] shifted;

  // >>> on a signed operand truncates toward -inf
  assign shifted = $signed(acc_i) >>> SHIFT;

  always_comb begin
    q_o = shifted[7:0];
    if (shifted > HI) begin
      q_o = 8'(INT8_MAX);
    end else if (shifted < LO) begin
      q_o = 8'(INT8_MIN);
    end
  end

endmodule

// File: rtl/pe_acc_drain.sv
// Snapshots a PE row's accumulators, clears the row, and streams the snapshot out
// one word per PE. Optional int8 requant on the output path: ACC_DRAIN_REQUANT_EN.
import accel_pkg::*;

module pe_acc_drain #(
  parameter int N_PE     = 8,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int RQ_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_PE*ACC_W-1:0]   acc_vec,
  input  logic                    start,
  output logic                    clr_pe,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ACC_W-1:0]        m_data,
  output logic [$clog2(N_PE)-1:0] m_idx,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int IDX_W = $clog2(N_PE);

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] shadow_q [N_PE];
  logic             snap;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             last;

  assign last = (idx_q == IDX_W'(N_PE - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (start) begin
          state_d = DRAIN_STREAM;
          idx_d   = '0;
          snap    = 1'b1;
          clr_d   = 1'b1;
        end
      end
      DRAIN_STREAM: begin
        ovr_d = start;
        if (m_ready) begin
          if (last) begin
            state_d = DRAIN_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN_IDLE;
      idx_q   <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PE; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (snap) begin
      for (int unsigned i = 0; i < N_PE; i++) begin
        shadow_q[i] <= acc_vec[i*ACC_W +: ACC_W];
      end
    end
  end

  assign clr_pe  = clr_q;
  assign m_valid = (state_q == DRAIN_STREAM);
  assign busy    = (state_q != DRAIN_IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;
  assign m_idx   = idx_q;
  assign m_last  = m_valid && last;

`ifdef ACC_DRAIN_REQUANT_EN
  logic [7:0] rq;

  sat_requant #(
    .ACC_W (ACC_W),
    .SHIFT (RQ_SHIFT)
  ) u_sat_requant (
    .acc_i (shadow_q[idx_q]),
    .q_o   (rq)
  );

  assign m_data = {{(ACC_W-8){rq[7]}}, rq};
`else
  logic unused_rq;

  assign unused_rq = ^{RQ_SHIFT, INT8_MIN, INT8_MAX};
  assign m_data    = shadow_q[idx_q];
`endif

endmodule

// File: tb/tb_pe_acc_drain.sv
// Self-checking bench for pe_acc_drain: vector table, directed corner sequences, random traffic.
module tb_pe_acc_drain;

  localparam int N = 8;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   acc_vec;
  logic             start;
  logic             clr_pe;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic [2:0]       m_idx;
  logic             m_last;
  logic             busy;
  logic             done;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  // reference model: queue of words still to be delivered
  bit         mbusy;
  logic [W-1:0] q[$];
  int         mpos;
  bit         e_clr, e_done, e_ovr;
  int         xfers;

  pe_acc_drain #(
    .N_PE     (N),
    .ACC_W    (W),
    .RQ_SHIFT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_vec (acc_vec),
    .start   (start),
    .clr_pe  (clr_pe),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] v);
`ifdef ACC_DRAIN_REQUANT_EN
    longint s;
    longint r;
    s = longint'($signed(v));
    r = (s >= 0) ? s / 256 : -((-s + 255) / 256);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return W'(r);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input int v);
    acc_vec[i*W +: W] = W'(v);
  endtask

  task automatic model_reset();
    mbusy = 0;
    q.delete();
    mpos = 0;
  endtask

  // One clock: drive inputs, advance model with pre-edge state, compare after the edge.
  task automatic step(input bit st, input bit rdy);
    bit pre_busy;
    start   = st;
    m_ready = rdy;
    e_clr = 0; e_done = 0; e_ovr = 0;
    pre_busy = mbusy;
    if (m_valid && rdy) xfers++;
    if (mbusy && rdy) begin
      void'(q.pop_front());
      mpos++;
      if (q.size() == 0) begin
        mbusy  = 0;
        e_done = 1;
      end
    end
    if (st) begin
      if (!pre_busy) begin
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(exp_word(acc_vec[i*W +: W]));
        mpos  = 0;
        mbusy = 1;
        e_clr = 1;
      end else begin
        e_ovr = 1;
      end
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    chk("m_valid", 64'(m_valid), 64'(mbusy));
    chk("busy",    64'(busy),    64'(mbusy));
    chk("clr_pe",  64'(clr_pe),  64'(e_clr));
    chk("done",    64'(done),    64'(e_done));
    chk("overrun", 64'(overrun), 64'(e_ovr));
    if (mbusy) begin
      chk("m_data", 64'(m_data), 64'(q[0]));
      chk("m_idx",  64'(m_idx),  64'(mpos));
      chk("m_last", 64'(m_last), 64'(q.size() == 1));
    end
  endtask

  typedef struct {
    bit         st;
    bit         rdy;
    bit         valid;
    bit         clr;
    bit         last;
    bit         dn;
    int         idx;
    logic [W-1:0] data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int x0;
    rst_n   = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    acc_vec = '0;
    xfers   = 0;
    model_reset();

    #12;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_clr",   64'(clr_pe),  64'd0);
    chk("rst_done",  64'(done),    64'd0);
    chk("rst_ovr",   64'(overrun), 64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_idx",   64'(m_idx),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: PE i -> i*1000-3000, full-rate drain
    for (int i = 0; i < N; i++) set_lane(i, i*1000 - 3000);
    tbl[0] = '{1, 1, 1, 1, 0, 0, 0, exp_word(W'(-3000))};
    for (int k = 1; k < 8; k++)
      tbl[k] = '{0, 1, 1, 0, (k == 7), 0, k, exp_word(W'(k*1000 - 3000))};
    tbl[8] = '{0, 1, 0, 0, 0, 1, 0, '0};
    tbl[9] = '{0, 1, 0, 0, 0, 0, 0, '0};
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].st, tbl[k].rdy);
      chk("tbl_valid", 64'(m_valid), 64'(tbl[k].valid));
      chk("tbl_clr",   64'(clr_pe),  64'(tbl[k].clr));
      chk("tbl_done",  64'(done),    64'(tbl[k].dn));
      if (tbl[k].valid) begin
        chk("tbl_data", 64'(m_data), 64'(tbl[k].data));
        chk("tbl_idx",  64'(m_idx),  64'(tbl[k].idx));
        chk("tbl_last", 64'(m_last), 64'(tbl[k].last));
      end
    end

    // Backpressure 1,0,0,1 with snapshot isolation (acc_vec overwritten right after start)
    for (int i = 0; i < N; i++) set_lane(i, 17*i + 5);
    step(1, 0);
    acc_vec = {N{32'h7FFF_FFFF}};
    x0 = xfers;
    for (int k = 0; k < 40 && mbusy; k++) step(1'b0, (k % 4 == 0) || (k % 4 == 3));
    chk("bp_xfers", 64'(xfers - x0), 64'd8);
    step(0, 1);

    // Overrun at beat 3 and on the last-beat cycle, then start in the done cycle
    for (int i = 0; i < N; i++) set_lane(i, -i*77);
    step(1, 1);
    step(0, 1); step(0, 1); step(0, 1);
    chk("ovr_beat3_idx", 64'(m_idx), 64'd3);
    step(1, 1);
    step(0, 1); step(0, 1); step(0, 1);
    chk("ovr_lastbeat", 64'(m_last), 64'd1);
    for (int i = 0; i < N; i++) set_lane(i, 1000 + i);
    step(1, 1);
    chk("ovr_done", 64'(done), 64'd1);
    step(1, 1);
    chk("new_snap_idx0", 64'(m_data), 64'(exp_word(W'(1000))));
    for (int k = 0; k < 12 && mbusy; k++) step(0, 1);
    step(0, 1);

    // Reset mid-stream at beat 4
    for (int i = 0; i < N; i++) set_lane(i, 5*i - 9);
    step(1, 1);
    for (int k = 0; k < 4; k++) step(0, 1);
    chk("pre_rst_idx", 64'(m_idx), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),    64'd0);
    chk("mid_rst_clr",   64'(clr_pe),  64'd0);
    chk("mid_rst_done",  64'(done),    64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < N; i++) set_lane(i, 3*i + 40);
    step(1, 1);
    chk("post_rst_idx", 64'(m_idx), 64'd0);
    for (int k = 0; k < 12 && mbusy; k++) step(0, 1);
    step(0, 1);

`ifdef ACC_DRAIN_REQUANT_EN
    acc_vec = '0;
    set_lane(0, 32'h0001_2345);
    set_lane(1, -300);
    set_lane(2, -40000);
    set_lane(3, 32'h0000_3FFF);
    step(1, 1);
    chk("rq_0", 64'(m_data), 64'(W'(127)));
    step(0, 1);
    chk("rq_1", 64'(m_data), 64'(W'(-2)));
    step(0, 1);
    chk("rq_2", 64'(m_data), 64'(W'(-128)));
    step(0, 1);
    chk("rq_3", 64'(m_data), 64'(W'(63)));
    for (int k = 0; k < 12 && mbusy; k++) step(0, 1);
    step(0, 1);
`endif

    // Random traffic: random data, ready and start; acc_vec churns throughout
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) acc_vec[i*W +: W] = $urandom;
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 40 && mbusy; k++) step(0, 1);
    chk("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
